// File: rtl/zx_pkg.sv
// Shared constants for the Spectrum bus-side controller: I/O port decode
// masks, the fixed 8000 bank and the interrupt-acknowledge decode.
package zx_pkg;

    // Port FE responds to any even address (A[0]==0).
    localparam logic [15:0] PORT_FE_MASK    = 16'h0001;

    // Port 7FFD: A[15]==0, A[1]==0, A[0]==1.
    localparam logic [15:0] PORT_7FFD_MASK  = 16'h8003;
    localparam logic [15:0] PORT_7FFD_MATCH = 16'h0001;

    // Kempston joystick is a full low-byte match.
    localparam logic [7:0]  PORT_KEMPSTON   = 8'h1F;

    // Bank permanently mapped at 8000-BFFF.
    localparam int          FIXED_BANK_8000 = 2;

    // Interrupt acknowledge: M1 together with IORQ.
    function automatic logic is_inta(input logic n_m1, input logic n_iorq);
        return !n_m1 && !n_iorq;
    endfunction

endpackage

// File: rtl/zx_int_gen.sv
// Maskable interrupt pulse generator: a falling edge of nvblank starts an
// INT_LEN-cycle low pulse on nINT. Edges inside a pulse do not retrigger;
// an interrupt acknowledge ends the pulse early.
module zx_int_gen
    import zx_pkg::*;
#(
    parameter int INT_LEN = 32
) (
    input  logic clk,
    input  logic nRESET,
    input  logic nvblank,
    input  logic nM1,
    input  logic nIORQ,
    output logic nINT
);

    logic       r_nvblank_q;
    logic       r_nint;
    logic [7:0] r_cnt;
    logic       w_fall;
    logic       w_inta;

    assign w_fall = r_nvblank_q && !nvblank;
    assign w_inta = is_inta(nM1, nIORQ);
    assign nINT   = r_nint;

    // Edge detector, pulse counter and acknowledge release.
    always_ff @(posedge clk) begin
        // The edge detector is always refreshed so an edge already
        // passed (e.g. across reset) never fires later.
        r_nvblank_q <= nvblank;
        if (!nRESET) begin
            r_nint <= 1'b1;
            r_cnt  <= 8'd0;
        end else if (!r_nint) begin
            if (w_inta || r_cnt == 8'd0) begin
                r_nint <= 1'b1;
                r_cnt  <= 8'd0;
            end else begin
                r_cnt <= r_cnt - 8'd1;
            end
        end else if (w_fall) begin
            r_nint <= 1'b0;
            r_cnt  <= 8'(INT_LEN - 1);
        end
    end

endmodule

// File: rtl/zx_port_mapper.sv
// Z80 bus-side controller for the 128K Spectrum: port FE / 7FFD latches,
// memory paging, I/O read mux and the timed nINT pulse.
// Optional feature macro: ZX_KEMPSTON_EN adds the joy input and port 1F.
module zx_port_mapper
    import zx_pkg::*;
#(
    parameter int BANK_BITS = 3,
    parameter int ROM_BITS  = 1,
    parameter int INT_LEN   = 32,
    parameter int SCR_BANK0 = 5,
    parameter int SCR_BANK1 = 7
) (
    input  logic                 clk,
    input  logic                 nRESET,
    input  logic [15:0]          A,
    input  logic [7:0]           D,
    input  logic                 nIORQ,
    input  logic                 nMREQ,
    input  logic                 nRD,
    input  logic                 nWR,
    input  logic                 nM1,
    input  logic                 nvblank,
    input  logic [4:0]           kbd,
    input  logic                 ear,
`ifdef ZX_KEMPSTON_EN
    input  logic [4:0]           joy,
`endif
    output logic [BANK_BITS+14:0] mem_addr,
    output logic                 mem_we,
    output logic [7:0]           io_dout,
    output logic                 io_oe,
    output logic                 scr_sel,
    output logic [2:0]           border,
    output logic                 speaker,
    output logic                 tape_out,
    output logic                 nINT
);

    // The shadow screen bank is only meaningful to the video unit, but it
    // must be an addressable bank.
    if (SCR_BANK1 >= (2 ** BANK_BITS)) begin : g_bad_scr_bank1
        $error("SCR_BANK1 out of range for BANK_BITS");
    end

    logic [2:0]           r_border;
    logic                 r_speaker;
    logic                 r_tape;
    logic [BANK_BITS-1:0] r_bank;
    logic [ROM_BITS-1:0]  r_rom;
    logic                 r_scr_sel;
    logic                 r_lock;
    logic                 r_io_wr_q;

    logic                 w_io_wr;
    logic                 w_wr_stb;
    logic                 w_sel_fe;
    logic                 w_sel_7ffd;
    logic                 w_is_rom;
    logic [BANK_BITS-1:0] w_page;
    logic [BANK_BITS-1:0] w_bank_d;
    logic                 w_unused_d;

    assign w_io_wr    = !nIORQ && !nWR && nM1;
    assign w_wr_stb   = w_io_wr && !r_io_wr_q;
    assign w_sel_fe   = (A & PORT_FE_MASK) == 16'h0000;
    assign w_sel_7ffd = (A & PORT_7FFD_MASK) == PORT_7FFD_MATCH;
    assign w_unused_d = ^D;

    // Bank bits 0..2 come from D[2:0]; any wider bank uses D[7:6].
    for (genvar gi = 0; gi < BANK_BITS; gi++) begin : g_bank_bit
        if (gi < 3) begin : g_low
            assign w_bank_d[gi] = D[gi];
        end else begin : g_high
            assign w_bank_d[gi] = D[gi + 3];
        end
    end

    // Port latches, written once per I/O write bus cycle.
    always_ff @(posedge clk) begin
        r_io_wr_q <= w_io_wr;
        if (!nRESET) begin
            r_border  <= 3'd0;
            r_speaker <= 1'b0;
            r_tape    <= 1'b0;
            r_bank    <= '0;
            r_rom     <= '0;
            r_scr_sel <= 1'b0;
            r_lock    <= 1'b0;
        end else if (w_wr_stb) begin
            if (w_sel_fe) begin
                r_border  <= D[2:0];
                r_tape    <= D[3];
                r_speaker <= D[4];
            end
            if (w_sel_7ffd && !r_lock) begin
                r_bank    <= w_bank_d;
                r_scr_sel <= D[3];
                r_rom     <= D[4 +: ROM_BITS];
                r_lock    <= D[5];
            end
        end
    end

    // Memory map by 16K quadrant.
    always_comb begin
        w_is_rom = 1'b0;
        w_page   = '0;
        unique case (A[15:14])
            2'b00: begin
                w_is_rom = 1'b1;
                w_page   = BANK_BITS'(r_rom);
            end
            2'b01:   w_page = BANK_BITS'(SCR_BANK0);
            2'b10:   w_page = BANK_BITS'(FIXED_BANK_8000);
            default: w_page = r_bank;
        endcase
    end

    assign mem_addr = {w_is_rom, w_page, A[13:0]};
    assign mem_we   = !nMREQ && !nWR && !w_is_rom;

    // I/O read data mux; never driven during interrupt acknowledge.
    always_comb begin
        io_oe   = !nIORQ && !nRD && nM1;
        io_dout = 8'hFF;
`ifdef ZX_KEMPSTON_EN
        if (A[7:0] == PORT_KEMPSTON) begin
            io_dout = {3'b000, joy};
        end else if (w_sel_fe) begin
            io_dout = {1'b1, ear, 1'b1, kbd};
        end
`else
        if (w_sel_fe) begin
            io_dout = {1'b1, ear, 1'b1, kbd};
        end
`endif
    end

    zx_int_gen #(
        .INT_LEN (INT_LEN)
    ) u_int_gen (
        .clk     (clk),
        .nRESET  (nRESET),
        .nvblank (nvblank),
        .nM1     (nM1),
        .nIORQ   (nIORQ),
        .nINT    (nINT)
    );

    assign scr_sel  = r_scr_sel;
    assign border   = r_border;
    assign speaker  = r_speaker;
    assign tape_out = r_tape;

endmodule

// File: doc/zx_port_mapper.md
Name: zx_port_mapper

Overview:
- Parametrised Z80 bus-side controller for the 128K-class Spectrum build: I/O port decode, memory paging, interrupt pulse generation.
- Replaces the ad-hoc FE latch, the fixed ROM write-guard and the raw-vblank nINT in the board top level.
- Sits between z80_top_direct_n and the dual-port memory/video/keyboard units.
- Produces the physical RAM address and write enable, the border/speaker latches, the I/O read data and a timed nINT.

Parameters:
BANK_BITS, 3, width of the C000 bank select; 2**BANK_BITS 16K RAM banks.
ROM_BITS, 1, width of the ROM page select; 2**ROM_BITS 16K ROM pages.
INT_LEN, 32, nINT low duration in clk cycles (1..255).
SCR_BANK0, 5, bank number of normal screen; also fixed at 4000.
SCR_BANK1, 7, bank number of shadow screen.

Ports:
clk  input  1  system clock; all state on posedge.
nRESET  input  1  synchronous active-low reset.
A  input  16  Z80 address bus.
D  input  8  Z80 data bus (write data).
nIORQ, nMREQ, nRD, nWR, nM1  input  1 each  Z80 strobes, active low.
nvblank  input  1  video vblank, low during vertical blank.
kbd  input  5  keyboard half-row bits for current A[15:8], active low.
ear  input  1  tape input.
mem_addr  output  BANK_BITS+15  {is_rom, page[BANK_BITS-1:0], A[13:0]}; ROM page zero-extended.
mem_we  output  1  RAM write enable.
io_dout  output  8  I/O read data.
io_oe  output  1  drive io_dout onto D.
scr_sel  output  1  0 = SCR_BANK0 displayed, 1 = SCR_BANK1.
border  output  3  border colour.
speaker  output  1  beeper bit.
tape_out  output  1  MIC bit.
nINT  output  1  maskable interrupt to CPU.

Behaviour:
- Reset (nRESET=0 at posedge): border=0, speaker=0, tape_out=0, bank=0, rom=0, scr_sel=0, lock=0, nINT=1, int counter=0, edge detectors loaded with current inputs.
- io_wr = !nIORQ & !nWR & nM1.
  - Registered copy io_wr_q.
  - Write action only on the cycle io_wr & !io_wr_q: exactly one action per bus cycle regardless of clk/CPU ratio.
- Port FE: decode A[0]==0. Write: border<=D[2:0], tape_out<=D[3], speaker<=D[4].
- Port 7FFD: decode A[15]==0 & A[1]==0 & A[0]==1.
  - Write when lock==0: bank<=D[BANK_BITS-1:0] (bits above 2 taken from D[7:6] when BANK_BITS>3), scr_sel<=D[3], rom<=D[4+ROM_BITS-1:4], lock<=D[5].
  - lock==1: writes ignored until reset.
- A single write decoding to both ports updates both.
- Memory map (combinational on A), by A[15:14]:
  - 00: ROM page rom, is_rom=1.
  - 01: bank SCR_BANK0.
  - 10: bank 2.
  - 11: bank `bank`.
- mem_we = !nMREQ & !nWR & !is_rom.
- I/O read: io_oe = !nIORQ & !nRD & nM1.
  - Port FE: io_dout = {1, ear, 1, kbd}.
  - Any other port, including 7FFD: io_dout = 8'hFF.
  - io_oe=0 during INTA (nM1=0).
- Interrupt:
  - Registered nvblank_q; falling edge (nvblank_q=1, nvblank=0) sets nINT=0 and counter=INT_LEN-1.
  - Counter decrements each clk; nINT returns to 1 on the cycle counter reaches 0 (low exactly INT_LEN cycles).
  - Edge during an active pulse is ignored (no retrigger).
  - INTA (!nM1 & !nIORQ) while nINT=0 releases nINT next cycle and clears counter.
- Reset mid-pulse: nINT=1 next cycle, and no pulse is generated for the edge already passed.

Optional Feature:
ZX_KEMPSTON_EN
- Defined:
  - Adds input port `joy` (5 bits, active high: R,L,D,U,Fire).
  - I/O read with A[7:0]==8'h1F returns {3'b000, joy}; takes precedence over FE decode for that address.
- Undefined: no joy port; 1F reads follow normal decode (A[0]=1 -> 8'hFF).

Decomposition:
- Package zx_pkg: port address constants (PORT_FE_MASK, PORT_7FFD decode bits, PORT_KEMPSTON), FIXED_BANK_8000=2, INTA decode helper function.
- One sub-module zx_int_gen: edge detect, INT_LEN counter and INTA release. Mapper, port latches and read mux stay in the top.

Test Plan:
1. Reset, then OUT (FE),8'h1D -> border=5, tape_out=1, speaker=1 one clk after strobe edge. Hold nWR low 10 clks -> single update only.
2. OUT (7FFD),8'h13 then read/write A=C000 -> mem_addr={0,3'd3,14'h0}, scr_sel=0, rom=1. A=0000 -> is_rom=1, and nMREQ/nWR low gives mem_we=0.
3. OUT (7FFD),8'h27 (lock, bank 7), then OUT (7FFD),8'h01 -> bank stays 7. Pulse nRESET low 1 clk -> bank=0, lock=0; the same write now takes effect.
4. nvblank 1->0 with INT_LEN=32 -> nINT low exactly 32 clks. Second falling edge at clk 10 of the pulse -> no extension.
5. nINT low, INTA (nM1=0, nIORQ=0) at clk 5 -> nINT=1 at clk 6. Also check io_oe=0 during INTA.
6. IN from port FE with kbd=5'b10110, ear=1 -> io_dout=8'hF6, io_oe=1. With ZX_KEMPSTON_EN and joy=5'h11, IN (1F) -> 8'h11. Without the macro -> 8'hFF.
